// File: rtl/axi_req_arbiter_pkg.sv
// Shared types for the two-port request arbiter
// in front of the simple AXI4-lite manager port.
package axi_req_arbiter_pkg;

    localparam int DEFAULT_AXI_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    // Latched command of the granted requester
    typedef struct packed {
        logic                              rd;
        logic                              wr;
        logic [DEFAULT_AXI_ADDR_WIDTH-1:0] addr;
        logic [31:0]                       data;
        logic [3:0]                        strobe;
        logic                              port;
    } arb_cmd_t;

endpackage

// File: rtl/axi_req_arbiter_rr.sv
// Two-way grant: combinational winner select with
// a registered record of the last port served.
module rr_arbiter2 #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_port,
    output logic       gnt_valid,
    output logic       gnt_port
);

    logic rr_last_q, rr_last_d;

    // Pick the winner; on a tie the port not served last wins
    always_comb begin
        gnt_valid = |req;
        gnt_port  = 1'b0;
        rr_last_d = upd ? upd_port : rr_last_q;
        if (req == 2'b11) begin
            gnt_port = FIXED_PRIORITY ? 1'b0 : ~rr_last_q;
        end else begin
            gnt_port = req[1];
        end
    end

    // Last-served register; port 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/axi_req_arbiter.sv
// Shares one simple manager port between the core data
// bus (port 0) and the debug/DMA master (port 1).
module axi_req_arbiter
    import axi_req_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEFAULT_AXI_ADDR_WIDTH,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_rd_en,
    input  logic                  s0_wr_en,
    input  logic [ADDR_WIDTH-1:0] s0_addr,
    input  logic [31:0]           s0_wr_data,
    input  logic [3:0]            s0_wr_strobe,
    output logic [31:0]           s0_rd_data,
    output logic                  s0_access_fault,
    output logic                  s0_busy,
    output logic                  s0_done,
    input  logic                  s1_rd_en,
    input  logic                  s1_wr_en,
    input  logic [ADDR_WIDTH-1:0] s1_addr,
    input  logic [31:0]           s1_wr_data,
    input  logic [3:0]            s1_wr_strobe,
    output logic [31:0]           s1_rd_data,
    output logic                  s1_access_fault,
    output logic                  s1_busy,
    output logic                  s1_done,
    output logic                  m_rd_en,
    output logic                  m_wr_en,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [31:0]           m_wr_data,
    output logic [3:0]            m_wr_strobe,
    input  logic [31:0]           m_rd_data,
    input  logic                  m_access_fault,
    input  logic                  m_busy
);

    arb_state_t  state_q, state_d;
    arb_cmd_t    cmd_q, cmd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        prev_busy_q, prev_busy_d;
    logic        seen_busy_q, seen_busy_d;
    logic        waited_q, waited_d;
    logic [1:0]  req;
    logic        gnt_valid, gnt_port;
    logic        rr_upd, issue, resp, m_done;

    assign req = {s1_rd_en | s1_wr_en, s0_rd_en | s0_wr_en};

    rr_arbiter2 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .upd      (rr_upd),
        .upd_port (cmd_q.port),
        .gnt_valid(gnt_valid),
        .gnt_port (gnt_port)
    );

    // Completion: busy falling edge, or a manager that
    // never raised busy within two cycles of the issue
    assign m_done = (prev_busy_q & ~m_busy)
                  | (waited_q & ~seen_busy_q & ~m_busy);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
            prev_busy_q <= 1'b0;
            seen_busy_q <= 1'b0;
            waited_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            prev_busy_q <= prev_busy_d;
            seen_busy_q <= seen_busy_d;
            waited_q    <= waited_d;
        end
    end

    // Next state, command latch and response capture
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        prev_busy_d = m_busy;
        seen_busy_d = seen_busy_q;
        waited_d    = waited_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    cmd_d.port = gnt_port;
                    if (gnt_port) begin
                        cmd_d.rd     = s1_rd_en;
                        cmd_d.wr     = s1_wr_en;
                        cmd_d.addr   = DEFAULT_AXI_ADDR_WIDTH'(s1_addr);
                        cmd_d.data   = s1_wr_data;
                        cmd_d.strobe = s1_wr_strobe;
                    end else begin
                        cmd_d.rd     = s0_rd_en;
                        cmd_d.wr     = s0_wr_en;
                        cmd_d.addr   = DEFAULT_AXI_ADDR_WIDTH'(s0_addr);
                        cmd_d.data   = s0_wr_data;
                        cmd_d.strobe = s0_wr_strobe;
                    end
                    rdata_d = '0;
                    fault_d = cmd_d.rd & cmd_d.wr;
                    state_d = fault_d ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (!m_busy) begin
                    seen_busy_d = 1'b0;
                    waited_d    = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                seen_busy_d = seen_busy_q | m_busy;
                waited_d    = 1'b1;
                if (m_done) begin
                    rdata_d = cmd_q.rd ? m_rd_data : '0;
                    fault_d = m_access_fault;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Manager request strobe and requester responses
    always_comb begin
        issue           = (state_q == ISSUE) & ~m_busy;
        resp            = (state_q == RESP);
        rr_upd          = resp;
        m_rd_en         = issue & cmd_q.rd;
        m_wr_en         = issue & cmd_q.wr;
        m_addr          = issue ? ADDR_WIDTH'(cmd_q.addr) : '0;
        m_wr_data       = issue ? cmd_q.data : '0;
        m_wr_strobe     = issue ? cmd_q.strobe : '0;
        s0_done         = resp & ~cmd_q.port;
        s1_done         = resp & cmd_q.port;
        s0_rd_data      = s0_done ? rdata_q : '0;
        s1_rd_data      = s1_done ? rdata_q : '0;
        s0_access_fault = s0_done & fault_q;
        s1_access_fault = s1_done & fault_q;
        s0_busy         = req[0] & ~s0_done;
        s1_busy         = req[1] & ~s1_done;
    end

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Scoreboard bench: instance 0 round-robin, instance 1
// fixed priority, each with a behavioural manager.
module tb_axi_req_arbiter;

    localparam logic [31:0] CCFG = 32'hC0DE0000;

    typedef struct {
        bit          port;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] rdata;
        bit          fault;
        bit          illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s0_rd_en[2], s0_wr_en[2];
    logic        s1_rd_en[2], s1_wr_en[2];
    logic [31:0] s0_addr[2], s1_addr[2];
    logic [31:0] s0_wr_data[2], s1_wr_data[2];
    logic [3:0]  s0_wr_strobe[2], s1_wr_strobe[2];
    logic [31:0] s0_rd_data[2], s1_rd_data[2];
    logic        s0_access_fault[2], s1_access_fault[2];
    logic        s0_busy[2], s1_busy[2];
    logic        s0_done[2], s1_done[2];
    logic        m_rd_en[2], m_wr_en[2];
    logic [31:0] m_addr[2], m_wr_data[2];
    logic [3:0]  m_wr_strobe[2];
    logic [31:0] m_rd_data[2];
    logic        m_access_fault[2], m_busy[2];

    int          cfg_lat[2];
    logic [31:0] cfg_rdata[2];
    bit          cfg_fault[2];
    int          mcnt[2];
    logic [31:0] lat_addr[2];

    exp_t q0[$];
    exp_t q1[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    axi_req_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIORITY(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .s0_rd_en(s0_rd_en[0]), .s0_wr_en(s0_wr_en[0]),
        .s0_addr(s0_addr[0]), .s0_wr_data(s0_wr_data[0]),
        .s0_wr_strobe(s0_wr_strobe[0]), .s0_rd_data(s0_rd_data[0]),
        .s0_access_fault(s0_access_fault[0]),
        .s0_busy(s0_busy[0]), .s0_done(s0_done[0]),
        .s1_rd_en(s1_rd_en[0]), .s1_wr_en(s1_wr_en[0]),
        .s1_addr(s1_addr[0]), .s1_wr_data(s1_wr_data[0]),
        .s1_wr_strobe(s1_wr_strobe[0]), .s1_rd_data(s1_rd_data[0]),
        .s1_access_fault(s1_access_fault[0]),
        .s1_busy(s1_busy[0]), .s1_done(s1_done[0]),
        .m_rd_en(m_rd_en[0]), .m_wr_en(m_wr_en[0]),
        .m_addr(m_addr[0]), .m_wr_data(m_wr_data[0]),
        .m_wr_strobe(m_wr_strobe[0]), .m_rd_data(m_rd_data[0]),
        .m_access_fault(m_access_fault[0]), .m_busy(m_busy[0])
    );

    axi_req_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIORITY(1'b1)) u_fp (
        .clk(clk), .rst(rst),
        .s0_rd_en(s0_rd_en[1]), .s0_wr_en(s0_wr_en[1]),
        .s0_addr(s0_addr[1]), .s0_wr_data(s0_wr_data[1]),
        .s0_wr_strobe(s0_wr_strobe[1]), .s0_rd_data(s0_rd_data[1]),
        .s0_access_fault(s0_access_fault[1]),
        .s0_busy(s0_busy[1]), .s0_done(s0_done[1]),
        .s1_rd_en(s1_rd_en[1]), .s1_wr_en(s1_wr_en[1]),
        .s1_addr(s1_addr[1]), .s1_wr_data(s1_wr_data[1]),
        .s1_wr_strobe(s1_wr_strobe[1]), .s1_rd_data(s1_rd_data[1]),
        .s1_access_fault(s1_access_fault[1]),
        .s1_busy(s1_busy[1]), .s1_done(s1_done[1]),
        .m_rd_en(m_rd_en[1]), .m_wr_en(m_wr_en[1]),
        .m_addr(m_addr[1]), .m_wr_data(m_wr_data[1]),
        .m_wr_strobe(m_wr_strobe[1]), .m_rd_data(m_rd_data[1]),
        .m_access_fault(m_access_fault[1]), .m_busy(m_busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Manager model: latches on an enable while idle, then
    // holds busy for cfg_lat cycles (0 = never busy).
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k]         <= 1'b0;
                mcnt[k]           <= 0;
                m_rd_data[k]      <= '0;
                m_access_fault[k] <= 1'b0;
            end else if (mcnt[k] != 0) begin
                if (mcnt[k] == 1) begin
                    m_busy[k]         <= 1'b0;
                    m_rd_data[k]      <= cfg_rdata[k] ^ lat_addr[k];
                    m_access_fault[k] <= cfg_fault[k];
                end
                mcnt[k] <= mcnt[k] - 1;
            end else if ((m_rd_en[k] | m_wr_en[k]) && !m_busy[k]) begin
                lat_addr[k] <= m_addr[k];
                if (cfg_lat[k] == 0) begin
                    m_rd_data[k]      <= cfg_rdata[k] ^ m_addr[k];
                    m_access_fault[k] <= cfg_fault[k];
                end else begin
                    m_busy[k]         <= 1'b1;
                    mcnt[k]           <= cfg_lat[k];
                    m_rd_data[k]      <= '0;
                    m_access_fault[k] <= 1'b0;
                end
            end
        end
    end

    // Scoreboard: issue and done checked against queue head
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (m_rd_en[k] | m_wr_en[k]) begin
                    if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                        chk("issue_unexp", 32'(m_rd_en[k] | m_wr_en[k]), 0);
                    end else begin
                        if (k == 0) me = q0[0];
                        else me = q1[0];
                        chk("issue_illegal", 32'(me.illegal), 0);
                        chk("issue_busy", 32'(m_busy[k]), 0);
                        chk("m_rd_en", 32'(m_rd_en[k]), 32'(me.rd));
                        chk("m_wr_en", 32'(m_wr_en[k]), 32'(me.wr));
                        chk("m_addr", m_addr[k], me.addr);
                        if (me.wr) begin
                            chk("m_wr_data", m_wr_data[k], me.data);
                            chk("m_wr_strobe", 32'(m_wr_strobe[k]),
                                32'(me.strb));
                        end
                    end
                end
                if (s0_done[k] | s1_done[k]) begin
                    if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                        chk("done_unexp", 32'(s0_done[k] | s1_done[k]), 0);
                    end else begin
                        if (k == 0) me = q0.pop_front();
                        else me = q1.pop_front();
                        chk("done_port", 32'(s1_done[k]), 32'(me.port));
                        chk("done_both", 32'(s0_done[k] & s1_done[k]), 0);
                        if (me.port) begin
                            chk("s1_rd_data", s1_rd_data[k], me.rdata);
                            chk("s1_fault", 32'(s1_access_fault[k]),
                                32'(me.fault));
                            chk("s0_rd_data_idle", s0_rd_data[k], 0);
                            chk("s0_fault_idle", 32'(s0_access_fault[k]), 0);
                        end else begin
                            chk("s0_rd_data", s0_rd_data[k], me.rdata);
                            chk("s0_fault", 32'(s0_access_fault[k]),
                                32'(me.fault));
                            chk("s1_rd_data_idle", s1_rd_data[k], 0);
                            chk("s1_fault_idle", 32'(s1_access_fault[k]), 0);
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input int k, input bit port, input bit rd,
                         input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        if (port) begin
            s1_rd_en[k] = rd; s1_wr_en[k] = wr; s1_addr[k] = addr;
            s1_wr_data[k] = data; s1_wr_strobe[k] = strb;
        end else begin
            s0_rd_en[k] = rd; s0_wr_en[k] = wr; s0_addr[k] = addr;
            s0_wr_data[k] = data; s0_wr_strobe[k] = strb;
        end
    endtask

    task automatic push_rd(input int k, input bit port,
                           input logic [31:0] addr);
        exp_t e;
        e.port = port; e.rd = 1'b1; e.wr = 1'b0; e.addr = addr;
        e.data = '0; e.strb = '0; e.rdata = CCFG ^ addr;
        e.fault = 1'b0; e.illegal = 1'b0;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Single transaction on the round-robin instance with
    // latency checks; call at #1 after a rising edge
    task automatic txn0(input bit port, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int lat,
                        input logic [31:0] cfg, input bit flt,
                        input int exp_done, input int drop_at,
                        input bit glitch);
        exp_t e;
        int   cyc;
        int   en_cyc;
        int   done_cyc;
        logic busy;
        cfg_lat[0] = lat; cfg_rdata[0] = cfg; cfg_fault[0] = flt;
        e.port = port; e.rd = rd; e.wr = wr; e.addr = addr;
        e.data = data; e.strb = strb; e.illegal = rd & wr;
        e.rdata = (rd && !wr) ? (cfg ^ addr) : 32'h0;
        e.fault = (rd && wr) ? 1'b1 : flt;
        q0.push_back(e);
        drive(0, port, rd, wr, addr, data, strb);
        cyc = 0; en_cyc = -1; done_cyc = -1;
        while (done_cyc < 0 && cyc < 60) begin
            @(negedge clk);
            busy = port ? s1_busy[0] : s0_busy[0];
            if (cyc == 0) chk("busy_req", 32'(busy), 1);
            if ((m_rd_en[0] | m_wr_en[0]) && en_cyc < 0) en_cyc = cyc;
            if (s0_done[0] | s1_done[0]) begin
                done_cyc = cyc;
                chk("busy_at_done", 32'(busy), 0);
            end
            if (cyc == drop_at) drive(0, port, 0, 0, addr, data, strb);
            if (glitch && cyc == 2) begin
                s1_addr[0] = 32'h999; s1_rd_en[0] = 1'b1;
            end
            if (glitch && cyc == 4) s1_rd_en[0] = 1'b0;
            cyc++;
        end
        @(posedge clk); #1;
        drive(0, port, 0, 0, addr, data, strb);
        chk("done_cycle", done_cyc, exp_done);
        chk("issue_cycle", en_cyc, (rd && wr) ? -1 : 1);
    endtask

    // Both ports request continuously until each
    // instance has completed its target count
    task automatic contend(input int n0, input int n1,
                           input logic [31:0] a0, input logic [31:0] a1);
        int c[2];
        int tgt[2];
        int t;
        tgt[0] = n0; tgt[1] = n1;
        for (int k = 0; k < 2; k++) begin
            c[k] = 0; cfg_lat[k] = 1; cfg_rdata[k] = CCFG;
            cfg_fault[k] = 1'b0;
            if (tgt[k] > 0) begin
                drive(k, 0, 1, 0, a0, 0, 0);
                drive(k, 1, 1, 0, a1, 0, 0);
            end
        end
        t = 0;
        while ((c[0] < tgt[0] || c[1] < tgt[1]) && t < 400) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                if (s0_done[k] | s1_done[k]) c[k]++;
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (c[k] >= tgt[k]) begin
                    drive(k, 0, 0, 0, a0, 0, 0);
                    drive(k, 1, 0, 0, a1, 0, 0);
                end
            end
            t++;
        end
        chk("contend_cnt0", c[0], tgt[0]);
        chk("contend_cnt1", c[1], tgt[1]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            drive(k, 0, 0, 0, 0, 0, 0);
            drive(k, 1, 0, 0, 0, 0, 0);
            cfg_lat[k] = 1; cfg_rdata[k] = '0; cfg_fault[k] = 1'b0;
            mcnt[k] = 0; lat_addr[k] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_m_rd_en", 32'(m_rd_en[k]), 0);
            chk("rst_m_wr_en", 32'(m_wr_en[k]), 0);
            chk("rst_m_addr", m_addr[k], 0);
            chk("rst_s0_done", 32'(s0_done[k]), 0);
            chk("rst_s1_done", 32'(s1_done[k]), 0);
            chk("rst_s0_rd_data", s0_rd_data[k], 0);
            chk("rst_s1_fault", 32'(s1_access_fault[k]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // read, 3 busy cycles: enable at 1, done at 6
        txn0(0, 1, 0, 32'h100, 0, 0, 3, 32'hDEADBEEF ^ 32'h100, 0,
             6, -1, 0);
        // illegal rd & wr: no issue, done at 1 with fault
        txn0(0, 1, 1, 32'h300, 32'h55, 4'hF, 2, 32'h0, 0, 1, -1, 0);
        // manager never raises busy: done at 4
        txn0(0, 1, 0, 32'h40, 0, 0, 0, 32'h0F0F0000, 0, 4, -1, 0);
        // drop after grant plus a port 1 glitch before grant
        txn0(0, 1, 0, 32'h80, 0, 0, 3, 32'h600DF00D, 0, 6, 3, 1);
        // port 1 write with manager fault, read data zeroed
        txn0(1, 0, 1, 32'h200, 32'h12345678, 4'b0011, 2,
             32'hBAD00000, 1, 5, -1, 0);

        // contention: rr alternates, fixed keeps port 0
        push_rd(0, 0, 32'h1000); push_rd(0, 1, 32'h2000);
        push_rd(0, 0, 32'h1000); push_rd(0, 1, 32'h2000);
        for (int i = 0; i < 4; i++) push_rd(1, 0, 32'h1000);
        contend(4, 4, 32'h1000, 32'h2000);
        chk("fp_q_empty", q1.size(), 0);

        // reset while waiting on the manager
        cfg_lat[0] = 6; cfg_rdata[0] = CCFG;
        push_rd(0, 0, 32'h500);
        drive(0, 0, 1, 0, 32'h500, 0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("wait_busy", 32'(m_busy[0]), 1);
        @(posedge clk); #1;
        q0.delete();
        rst = 1'b1;
        drive(0, 0, 0, 0, 32'h500, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_m_rd_en", 32'(m_rd_en[0]), 0);
        chk("mid_rst_m_addr", m_addr[0], 0);
        chk("mid_rst_s0_done", 32'(s0_done[0]), 0);
        chk("mid_rst_s0_rd_data", s0_rd_data[0], 0);
        chk("mid_rst_s0_fault", 32'(s0_access_fault[0]), 0);
        @(posedge clk); #1;
        push_rd(0, 0, 32'h4); push_rd(0, 1, 32'h8);
        contend(2, 0, 32'h4, 32'h8);

        repeat (4) @(posedge clk);
        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
